// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding bus access with byte-lane steering, load extension and a timeout.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses finish at once with err instead of going to the bus.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [2:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   size_t      ld_size;
   logic       ld_signed;
   logic       ld_pend;
   logic [1:0] ld_off;

   logic       is_store;
   logic       is_load;
   logic       access;
   logic       sgn;
   logic       trap;
   size_t      size;
   logic [1:0] off;

   function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] o);
      case (sz)
         SZ_B:    lane_mask = 4'b0001 << o;
         SZ_H:    lane_mask = 4'b0011 << o;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input size_t sz, input logic [31:0] d);
      case (sz)
         SZ_B:    replicate = {4{d[7:0]}};
         SZ_H:    replicate = {2{d[15:0]}};
         default: replicate = d;
      endcase
   endfunction

   function automatic logic [31:0] extract(input size_t sz, input logic s, input logic [1:0] o,
                                           input logic [31:0] d);
      logic [31:0] lane;
      lane = d >> {o, 3'b000};
      case (sz)
         SZ_B:    extract = {{24{s & lane[7]}}, lane[7:0]};
         SZ_H:    extract = {{16{s & lane[15]}}, lane[15:0]};
         default: extract = d;
      endcase
   endfunction

   // A store wins over a simultaneous load.
   always_comb begin
      is_store = (mem_write != 2'b00);
      is_load  = load_en && !is_store;
      access   = is_store || is_load;
      size     = SZ_W;
      sgn      = 1'b0;
      if (is_store) begin
         case (mem_write)
            2'b01:   size = SZ_B;
            2'b10:   size = SZ_H;
            default: size = SZ_W;
         endcase
      end else begin
         case (mem_read)
            3'b001:  begin size = SZ_B; sgn = 1'b1; end
            3'b010:  begin size = SZ_H; sgn = 1'b1; end
            3'b011:  size = SZ_B;
            3'b100:  size = SZ_H;
            default: size = SZ_W;
         endcase
      end
      case (size)
         SZ_B:    off = addr[1:0];
         SZ_H:    off = {addr[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   assign stall = !rst && ((state == BUSY) || ((state == IDLE) && access));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
         err       <= 1'b0;
         ld_size   <= SZ_W;
         ld_signed <= 1'b0;
         ld_pend   <= 1'b0;
         ld_off    <= '0;
      end else begin
         rdata <= '0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (access && trap) begin
                  err   <= 1'b1;
                  state <= DONE;
               end else if (access) begin
                  cnt       <= '0;
                  bus_req   <= 1'b1;
                  bus_we    <= is_store;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= lane_mask(size, off);
                  bus_wdata <= replicate(size, wdata);
                  ld_pend   <= is_load;
                  ld_size   <= size;
                  ld_signed <= sgn;
                  ld_off    <= off;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  state   <= DONE;
                  if (ld_pend)
                     rdata <= extract(ld_size, ld_signed, ld_off, bus_rdata);
               end else if (cnt == LAST) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  err     <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               ld_pend <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of BUSY cycles without bus_ack before the access is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port load_en, input, 1, a load is present in the MEM stage (ResultSrc==01).
REQ-005 SHALL have port mem_read, input, 3, the load kind: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu.
REQ-006 SHALL have port mem_write, input, 2, the store kind: 00 none, 01 sb, 10 sh, 11 sw.
REQ-007 SHALL have ports addr and wdata, input, 32 each, the byte address from the ALU result and the rs2 store data.
REQ-008 SHALL have port rdata, output, 32, the extended load result, valid in DONE.
REQ-009 SHALL have port stall, output, 1, which freezes the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 SHALL have port err, output, 1, pulsed in DONE when the access aborted.
REQ-011 SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, 32), bus_wdata (output, 32) and bus_be (output, 4); all are registered.
REQ-012 SHALL have ports bus_ack (input, 1) and bus_rdata (input, 32).

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL treat the access as a store when mem_write!=00 and as a load when load_en=1; a store SHALL take priority when both are set.
REQ-015 In IDLE with an access, SHALL assert stall combinationally, then on the next edge go to BUSY and register:
- bus_req=1;
- bus_addr={addr[31:2],2'b00};
- bus_we=1 for stores.
REQ-016 SHALL drive bus_be as follows:
- sb/lb/lbu: 4'b0001<<addr[1:0];
- sh/lh/lhu: 4'b0011<<addr[1:0];
- sw/lw: 4'b1111.
REQ-017 SHALL replicate store data into bus_wdata: byte x4, half x2, word as-is.
REQ-018 In BUSY, SHALL hold stall=1 and keep all bus outputs stable until bus_ack=1.
REQ-019 On bus_ack in BUSY, SHALL clear bus_req and bus_we and go to DONE; for loads it SHALL capture the lane selected by addr[1:0]:
- lb/lh: sign-extended;
- lbu/lhu: zero-extended;
- lw: full word.
REQ-020 In DONE, SHALL deassert stall, hold rdata valid for exactly one cycle, ignore the inputs, and return to IDLE.
REQ-021 SHALL give a minimum access cost of 2 stall cycles (ack in the first BUSY cycle).
REQ-022 SHALL count consecutive BUSY cycles in an 8-bit counter cleared on entry to BUSY; when the count reaches TIMEOUT with no ack, SHALL go to DONE with err=1 and rdata=0 and drop bus_req.
REQ-023 SHALL ignore bus_ack outside BUSY.
REQ-024 SHALL hold rdata at 0 in IDLE when no load is being completed.
REQ-025 With no access pending in IDLE, SHALL leave stall=0 and the bus idle.

Reset
REQ-026 rst=1 SHALL immediately force:
- state=IDLE;
- bus_req=0, bus_we=0, bus_be=0;
- bus_addr=0, bus_wdata=0;
- rdata=0, err=0, timeout counter=0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the access with no DONE cycle; after release the FSM SHALL restart from IDLE.

Configuration
REQ-028 SHALL support the macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go IDLE->DONE directly with err=1, no bus_req, rdata=0 and 1 stall cycle.
- Undefined: such addresses SHALL be issued with addr[1:0] ignored for word accesses and addr[0] ignored for halfword accesses, and err SHALL come only from timeout.

Verification
REQ-029 lb with addr=0x103 and bus_rdata=0x80FFFFFF acked in the first BUSY cycle -> rdata=0xFFFFFF80 in DONE, stall high for exactly 2 cycles.
REQ-030 sh with addr=0x202 and wdata=0x0000BEEF -> bus_be=4'b1100, bus_wdata=0xBEEFBEEF, bus_we=1, bus_addr=0x200.
REQ-031 lw with ack never given and TIMEOUT=16 -> 16 BUSY cycles, then DONE with err=1, rdata=0, bus_req=0.
REQ-032 load_en=1 and mem_write=11 together -> store performed, bus_we=1, rdata=0.
REQ-033 rst pulse during BUSY -> bus_req=0 and stall=0 before the next clk edge; a following lhu at addr 0x10 with bus_rdata=0x0000F00D gives rdata=0x0000F00D.
REQ-034 lw with addr=0x3 -> with LSU_MISALIGN_TRAP_EN: err=1, no bus_req, 1 stall cycle; without it: bus_addr=0x0, bus_be=4'b1111.
